// File: rtl/phy_pkg.sv
// Shared PHY link definitions used by both the transmit serializer and the
// receive deserializer.
//   IDLE_SYM / FRAME_SYM : idle-frame symbols
//   LOCK_FRAMES          : consecutive idle frames needed for receive lock
//   NUM_LANES            : lane count of the parallel side
package phy_pkg;

    localparam logic [7:0] IDLE_SYM    = 8'hBC;
    localparam logic [7:0] FRAME_SYM   = 8'h7C;
    localparam int         LOCK_FRAMES = 2;
    localparam int         NUM_LANES   = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // Lane 0 idles with FRAME_SYM, the other lanes with IDLE_SYM.
    function automatic logic lane_valid(input logic [7:0] b, input logic is_lane0);
        return is_lane0 ? (b != FRAME_SYM) : (b != IDLE_SYM);
    endfunction

endpackage

// File: rtl/ser2par_8.sv
// 8-bit serial-to-parallel converter.
//   clk_32f   : bit clock
//   rst       : asynchronous active-high reset
//   data_in   : serial data, MSB first
//   bit_clr   : restart the bit counter (next edge begins a new byte)
//   rx_byte   : shift register contents including the bit sampled this edge
//   byte_done : the bit sampled this edge completes a byte
module ser2par_8 (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       data_in,
    input  logic       bit_clr,
    output logic [7:0] rx_byte,
    output logic       byte_done
);

    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        sh_d      = {sh_q[6:0], data_in};
        bit_cnt_d = bit_clr ? 3'd0 : bit_cnt_q + 3'd1;
        // Look at the value sh takes on this edge so decisions line up with it.
        rx_byte   = sh_d;
        byte_done = (bit_cnt_q == 3'd7);
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            sh_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/phy_rx_deser.sv
// Receive deserializer for the 4-lane PHY link. Finds byte/frame alignment
// from idle frames, then rebuilds the four lanes once per 32-bit frame.
//   clk_32f           : bit clock
//   rst               : asynchronous active-high reset
//   data_in           : serial data, lane 0 first, MSB first
//   out0..out3        : recovered lane bytes (hold value when lane invalid)
//   valid_out0..3     : lane byte valid for the current publish
//   active            : high while locked
module phy_rx_deser
    import phy_pkg::*;
(
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       active
);

    rx_state_e state_q, state_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] hold_q [NUM_LANES];
    logic [7:0] hold_d [NUM_LANES];
    logic       pub_q, pub_d;
    logic [7:0] out_q [NUM_LANES];
    logic [7:0] out_d [NUM_LANES];
    logic [NUM_LANES-1:0] valid_q, valid_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       bit_clr;
    logic [7:0] exp_byte;

    ser2par_8 u_ser2par (
        .clk_32f   (clk_32f),
        .rst       (rst),
        .data_in   (data_in),
        .bit_clr   (bit_clr),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        hold_d      = hold_q;
        pub_d       = 1'b0;
        bit_clr     = 1'b0;
        exp_byte    = (byte_cnt_q == 2'd0) ? FRAME_SYM : IDLE_SYM;

        unique case (state_q)
            SEARCH: begin
                if (rx_byte == FRAME_SYM) begin
                    state_d     = VERIFY;
                    bit_clr     = 1'b1;
                    byte_cnt_d  = 2'd1;
                    frame_cnt_d = 3'd0;
                end
            end
            VERIFY: begin
                if (byte_done) begin
                    if (rx_byte != exp_byte) begin
                        state_d = SEARCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            frame_cnt_d = (frame_cnt_q == 3'd7) ? 3'd7 : frame_cnt_q + 3'd1;
                            if (frame_cnt_d == 3'(LOCK_FRAMES)) begin
                                state_d    = LOCKED;
                                byte_cnt_d = 2'd0;
                            end
                        end
                    end
                end
            end
            LOCKED: begin
                if (byte_done) begin
                    hold_d[byte_cnt_q] = rx_byte;
                    byte_cnt_d         = byte_cnt_q + 2'd1;
                    pub_d              = (byte_cnt_q == 2'd3);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Publish one edge after lane 3 lands in the holding registers.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (pub_q) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_valid(hold_q[k], k == 0)) begin
                    out_d[k]   = hold_q[k];
                    valid_d[k] = 1'b1;
                end else begin
                    valid_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            byte_cnt_q  <= 2'd0;
            frame_cnt_q <= 3'd0;
            pub_q       <= 1'b0;
            valid_q     <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                hold_q[k] <= 8'h00;
                out_q[k]  <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pub_q       <= pub_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
        end
    end

    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign out2       = out_q[2];
    assign out3       = out_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];
    assign active     = (state_q == LOCKED);

endmodule

// File: tb/tb_phy_rx_deser.sv
module tb_phy_rx_deser;

    localparam logic [7:0] T_IDLE  = 8'hBC;
    localparam logic [7:0] T_FRAME = 8'h7C;
    localparam int         T_LOCK  = 2;

    logic       clk_32f = 1'b0;
    logic       rst     = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       active;

    always #5 clk_32f = ~clk_32f;

    phy_rx_deser dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .data_in    (data_in),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .active     (active)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: works on the whole received bit history and decides
    // everything from bit positions relative to the detected alignment.
    bit         hist[$];
    int         m_mode;    // 0 search, 1 verify, 2 locked
    int         m_anchor;  // bit index where FRAME_SYM was found
    int         m_lock;    // bit index on which lock was declared
    logic [7:0] m_out[4];
    logic [3:0] m_val;     // {lane0, lane1, lane2, lane3}

    typedef struct packed {
        logic [31:0] din;   // lane0..lane3 bytes
        logic [31:0] eout;  // expected out0..out3
        logic [3:0]  ev;    // expected {valid_out0..valid_out3}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_snap();
        return {27'd0, out0, out1, out2, out3,
                valid_out0, valid_out1, valid_out2, valid_out3, active};
    endfunction

    function automatic logic [63:0] model_snap();
        return {27'd0, m_out[0], m_out[1], m_out[2], m_out[3], m_val, (m_mode == 2)};
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode   = 0;
        m_anchor = 0;
        m_lock   = 0;
        m_val    = 4'b0000;
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    endtask

    // The 8 bits ending at bit index e (bits before reset release read as 0).
    function automatic logic [7:0] win(input int e);
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int j = 0; j < 8; j++) begin
            idx = e - 7 + j;
            w   = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic model_step(input bit b);
        int e, d, k;
        logic [7:0] by;
        hist.push_back(b);
        e = hist.size() - 1;
        if (m_mode == 2 && (e - 1) > m_lock && ((e - 1 - m_lock) % 32) == 0) begin
            for (int i = 0; i < 4; i++) begin
                by = win(e - 1 - 8 * (3 - i));
                if ((i == 0) ? (by != T_FRAME) : (by != T_IDLE)) begin
                    m_out[i]     = by;
                    m_val[3 - i] = 1'b1;
                end else begin
                    m_val[3 - i] = 1'b0;
                end
            end
        end
        if (m_mode == 0) begin
            if (win(e) == T_FRAME) begin
                m_mode   = 1;
                m_anchor = e;
            end
        end else if (m_mode == 1) begin
            d = e - m_anchor;
            if ((d % 8) == 0) begin
                k = d / 8;
                if (win(e) != (((k % 4) == 0) ? T_FRAME : T_IDLE)) m_mode = 0;
                else if (k == 4 * T_LOCK - 1) begin
                    m_mode = 2;
                    m_lock = e;
                end
            end
        end
    endtask

    task automatic tick(input bit b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(b);
        chk("model", dut_snap(), model_snap());
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tick(v[i]);
    endtask

    task automatic send_idle_frame();
        send_byte(T_FRAME);
        for (int i = 0; i < 3; i++) send_byte(T_IDLE);
    endtask

    // Hold reset with random data, then release so the next edge samples bit 0.
    task automatic reset_hold(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            chk("reset", dut_snap(), 64'd0);
        end
        model_reset();
        rst = 1'b0;
    endtask

    vec_t vecs[5];
    bit   q[$];

    initial begin
        model_reset();
        vecs[0] = '{din: 32'hAACCEEDA, eout: 32'hAACCEEDA, ev: 4'b1111};
        vecs[1] = '{din: 32'hBBDDFFFA, eout: 32'hBBDDFFFA, ev: 4'b1111};
        vecs[2] = '{din: 32'hAACCBCDA, eout: 32'hAACCFFDA, ev: 4'b1101};
        vecs[3] = '{din: 32'h7C112233, eout: 32'hAA112233, ev: 4'b0111};
        vecs[4] = '{din: 32'h7CBCBCBC, eout: 32'hAA112233, ev: 4'b0000};

        // Reset values under random data.
        reset_hold(10);

        // Lock: 7C completes on bit index 7, so lock lands on bit index 63.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] f;
            f = 32'h7CBCBCBC;
            tick(f[31 - (i % 32)]);
            if (i == 62) chk("lock_early", 64'(active), 64'd0);
            if (i == 63) chk("lock_time", 64'(active), 64'd1);
        end

        // Table-driven data frames; each publish is seen on the first bit of
        // the following frame.
        q.delete();
        for (int v = 0; v < 5; v++)
            for (int i = 31; i >= 0; i--) q.push_back(vecs[v].din[i]);
        for (int i = 0; i < 32; i++) q.push_back(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            tick(q[i]);
            if (i > 0 && (i % 32) == 0)
                chk($sformatf("vec%0d", i / 32 - 1),
                    {28'd0, out0, out1, out2, out3, valid_out0, valid_out1, valid_out2, valid_out3},
                    {28'd0, vecs[i / 32 - 1].eout, vecs[i / 32 - 1].ev});
        end

        // Asynchronous reset mid-frame while locked.
        send_byte(8'h12);
        tick(1'b1); tick(1'b0); tick(1'b1);
        #3 rst = 1'b1;
        #1 chk("async_reset", dut_snap(), 64'd0);
        reset_hold(4);

        // False alignment: 7C followed by 3C must not lock.
        send_byte(T_FRAME);
        send_byte(8'h3C);
        send_byte(T_IDLE);
        chk("false_align", 64'(active), 64'd0);
        send_idle_frame();
        send_idle_frame();
        chk("relock", 64'(active), 64'd1);
        send_byte(8'h5A); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_idle_frame();

        // Bit-slip: random 3-bit prefix, lock, then random data frames.
        reset_hold(3);
        for (int i = 0; i < 3; i++) tick(1'($urandom));
        send_idle_frame();
        send_idle_frame();
        chk("slip_lock", 64'(active), 64'd1);
        for (int f = 0; f < 4; f++)
            for (int l = 0; l < 4; l++) send_byte(8'($urandom));
        send_idle_frame();
        chk("slip_active", 64'(active), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_deser.md
# phy_rx_deser

Receive end of the 4-lane PHY link. Accepts the 1-bit serial stream produced by the transmit serializer at clk_32f and finds byte and frame alignment from idle symbols. Rebuilds the four 8-bit lanes with per-lane valid flags. Sits between the serial line and the lane-side logic, producing the same lane/valid format that the transmit side consumes.

## Interface
- IDLE_SYM, 8'hBC: symbol sent in lanes 1-3 of an idle frame, and in any lane slot whose valid is low.
- FRAME_SYM, 8'h7C: symbol sent in lane 0 of an idle frame, and in a lane-0 slot whose valid is low.
- LOCK_FRAMES, 2: number of consecutive idle frames at one alignment needed for lock (range 1-7).
- clk_32f  in  1  bit clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  serial data, one bit per clk_32f, MSB of each byte first.
- out0, out1, out2, out3  out  8 each  recovered lane bytes.
- valid_out0, valid_out1, valid_out2, valid_out3  out  1 each  lane byte valid.
- active  out  1  high while in LOCKED.

## Operation
- Frame format: 4 bytes, 32 bits, lane 0 first, MSB first. An idle frame is {FRAME_SYM, IDLE_SYM, IDLE_SYM, IDLE_SYM}.
- Shift register: sh <= {sh[6:0], data_in} every cycle in every state.
- SEARCH state:
  - Compare sh to FRAME_SYM every cycle (bitwise sliding).
  - On a match, go to VERIFY with bit_cnt=0, byte_cnt=1, frame_cnt=0.
- VERIFY state:
  - bit_cnt counts 0..7. When bit_cnt wraps to 0, sh holds a complete byte.
  - Expected byte is FRAME_SYM if byte_cnt==0, otherwise IDLE_SYM.
  - On a mismatch, go to SEARCH, starting the search at the next cycle's sh.
  - On a match with byte_cnt==3, increment frame_cnt.
  - When frame_cnt reaches LOCK_FRAMES, go to LOCKED with byte_cnt=0.
  - The frame that began with the detected FRAME_SYM counts as frame 1.
- LOCKED state:
  - At each byte boundary, store sh into holding register hold[byte_cnt].
  - A slot is valid if and only if hold != IDLE_SYM (lanes 1-3), or hold != FRAME_SYM (lane 0).
  - On completion of lane 3, publish all four lanes at once:
    - For valid lanes, outK <= byte and valid_outK <= 1.
    - For invalid lanes, outK holds its previous value and valid_outK <= 0.
- LOCKED never exits except by rst. Data values equal to the lane's idle symbol are not transmittable; the transmit side guarantees this.
- bit_cnt is 3 bits and wraps 7->0. byte_cnt is 2 bits and wraps 3->0. frame_cnt is 3 bits and saturates.

## Timing
- Reset (async assert, synchronous-edge release):
  - state=SEARCH; sh, bit_cnt, byte_cnt and frame_cnt are 0.
  - out0-3 = 8'h00, valid_out0-3 = 0, active = 0.
- active rises on the same edge that enters LOCKED: with LOCK_FRAMES=2, 56 cycles after the edge on which sh first equalled FRAME_SYM.
- Publish latency: outputs and valids update on the clk_32f edge after the edge that samples the last bit of the lane-3 byte.
- Outputs are stable for 32 cycles between publishes, which is one clk_f period.
- Valids are registered and never glitch. They stay 0 between reset and the first publish after lock.
- A FRAME_SYM pattern straddling bit positions during SEARCH is a legal trigger. Any wrong alignment is rejected in VERIFY within 8 cycles of the next byte boundary.
- rst asserted mid-frame or mid-VERIFY:
  - All state clears immediately and any partial holding data is discarded.
  - A full relock is required.

## Structure
- Shared package phy_pkg:
  - constants IDLE_SYM=8'hBC and FRAME_SYM=8'h7C, which the transmit serializer also uses;
  - the state encoding SEARCH/VERIFY/LOCKED as a 2-bit localparam set;
  - the lane count of 4.
- One natural sub-module, ser2par_8. It contains the shift register plus bit_cnt and reports byte_done and byte.
- FSM, frame counting, holding registers and output publishing stay in phy_rx_deser.

## Test plan
- Reset values: hold rst=1 with random data_in → all out*=8'h00, valid_out*=0, active=0. Assert rst mid-LOCKED → same values on the same edge.
- Lock: after rst release, drive 2 idle frames (7C BC BC BC ×2) → active=1 exactly 56 cycles after the first 7C fully shifted in.
- Data frame: after lock, send AA CC EE DA → out0..3=AA,CC,EE,DA and valid_out0..3=1111, one cycle after the last bit. Then send BB DD FF FA → the next publish shows those values 32 cycles later.
- Invalid slot: after lock, send AA CC BC DA → valid_out2=0 with out2 unchanged; lanes 0, 1 and 3 are updated with valid=1. Send 7C in lane 0 → valid_out0=0.
- False alignment: send 7C followed by 3C → return to SEARCH and active stays 0. Then send two clean idle frames → lock.
- Bit-slip: prepend 3 random bits before idle frames → lock still achieved, and later data frames are recovered correctly.
